// File: rtl/alu_arbiter_pkg.sv
// Shared ALU op codes, legality check and arbiter FSM state type.
// Op codes are the 5 decoded bits; bit 5 of the request op is ignored upstream.
package alu_pkg;

    localparam logic [4:0] ALU_ADD  = 5'b01000;
    localparam logic [4:0] ALU_SUB  = 5'b11000;
    localparam logic [4:0] ALU_SLL  = 5'b01001;
    localparam logic [4:0] ALU_SLT  = 5'b01010;
    localparam logic [4:0] ALU_SLTU = 5'b01011;
    localparam logic [4:0] ALU_XOR  = 5'b01100;
    localparam logic [4:0] ALU_SRL  = 5'b01101;
    localparam logic [4:0] ALU_SRA  = 5'b11101;
    localparam logic [4:0] ALU_OR   = 5'b01110;
    localparam logic [4:0] ALU_AND  = 5'b01111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    function automatic logic alu_op_legal(input logic [4:0] op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
            ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response channels of the two ALU requesters plus the busy flag.
// The slave side is the arbiter; the master side drives requests and takes responses.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [5:0]  req0_op;
    logic [31:0] req0_rv1;
    logic [31:0] req0_rv2;
    logic        resp0_valid;
    logic        resp0_ready;
    logic [31:0] resp0_data;
    logic        resp0_err;

    logic        req1_valid;
    logic        req1_ready;
    logic [5:0]  req1_op;
    logic [31:0] req1_rv1;
    logic [31:0] req1_rv2;
    logic        resp1_valid;
    logic        resp1_ready;
    logic [31:0] resp1_data;
    logic        resp1_err;

    logic        busy;

    modport slave (
        input  req0_valid, req0_op, req0_rv1, req0_rv2, resp0_ready,
        input  req1_valid, req1_op, req1_rv1, req1_rv2, resp1_ready,
        output req0_ready, resp0_valid, resp0_data, resp0_err,
        output req1_ready, resp1_valid, resp1_data, resp1_err,
        output busy
    );

    modport master (
        output req0_valid, req0_op, req0_rv1, req0_rv2, resp0_ready,
        output req1_valid, req1_op, req1_rv1, req1_rv2, resp1_ready,
        input  req0_ready, resp0_valid, resp0_data, resp0_err,
        input  req1_ready, resp1_valid, resp1_data, resp1_err,
        input  busy
    );
endinterface

// File: rtl/alu_arbiter_alu32.sv
// Purely combinational 32-bit integer ALU; undecoded op codes yield zero.
module alu32
    import alu_pkg::*;
(
    input  logic [4:0]  i_op,
    input  logic [31:0] i_rv1,
    input  logic [31:0] i_rv2,
    output logic [31:0] o_res
);

    logic [4:0] w_shamt;
    assign w_shamt = i_rv2[4:0];

    always_comb begin
        o_res = '0;
        case (i_op)
            ALU_ADD:  o_res = i_rv1 + i_rv2;
            ALU_SUB:  o_res = i_rv1 - i_rv2;
            ALU_SLL:  o_res = i_rv1 << w_shamt;
            ALU_SLT:  o_res = {31'd0, $signed(i_rv1) < $signed(i_rv2)};
            ALU_SLTU: o_res = {31'd0, i_rv1 < i_rv2};
            ALU_XOR:  o_res = i_rv1 ^ i_rv2;
            ALU_SRL:  o_res = i_rv1 >> w_shamt;
            ALU_SRA:  o_res = $unsigned($signed(i_rv1) >>> w_shamt);
            ALU_OR:   o_res = i_rv1 | i_rv2;
            ALU_AND:  o_res = i_rv1 & i_rv2;
            default:  o_res = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between two requesters, one transaction in flight.
// Accept at T, result valid at T+2, held until the owning requester takes it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter bit RR_INIT = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    arb_state_t  r_state;
    arb_state_t  w_state_nxt;
    logic        r_ptr;
    logic        r_owner;
    logic [4:0]  r_op;
    logic [31:0] r_rv1;
    logic [31:0] r_rv2;
    logic [31:0] r_data;
    logic        r_err;

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_resp_hs;
    logic        w_resp_on;
    logic [31:0] w_alu_res;
    logic        w_unused_op5;

    assign w_unused_op5 = bus.req0_op[5] ^ bus.req1_op[5];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // A lone valid requester wins outright; the pointer only breaks ties.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_resp_hs   = 1'b0;
        case (r_state)
            IDLE: begin
                w_gnt0 = bus.req0_valid & (~bus.req1_valid | ~r_ptr);
                w_gnt1 = bus.req1_valid & (~bus.req0_valid |  r_ptr);
                if (w_gnt0 | w_gnt1) w_state_nxt = EXEC;
            end
            EXEC: w_state_nxt = RESP;
            RESP: begin
                w_resp_hs = r_owner ? bus.resp1_ready : bus.resp0_ready;
                if (w_resp_hs) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= RR_INIT;
            r_owner <= 1'b0;
            r_op    <= '0;
            r_rv1   <= '0;
            r_rv2   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_gnt0 | w_gnt1) begin
                r_owner <= w_gnt1;
                r_ptr   <= w_gnt0;
                r_op    <= w_gnt1 ? bus.req1_op[4:0] : bus.req0_op[4:0];
                r_rv1   <= w_gnt1 ? bus.req1_rv1     : bus.req0_rv1;
                r_rv2   <= w_gnt1 ? bus.req1_rv2     : bus.req0_rv2;
            end
            if (r_state == EXEC) begin
                r_data <= w_alu_res;
                r_err  <= ~alu_op_legal(r_op);
            end
        end
    end

    alu32 u_alu (
        .i_op  (r_op),
        .i_rv1 (r_rv1),
        .i_rv2 (r_rv2),
        .o_res (w_alu_res)
    );

    // The non-owner channel is forced to zero so only one response is ever visible.
    assign w_resp_on       = (r_state == RESP);
    assign bus.req0_ready  = w_gnt0;
    assign bus.req1_ready  = w_gnt1;
    assign bus.busy        = (r_state != IDLE);
    assign bus.resp0_valid = w_resp_on & ~r_owner;
    assign bus.resp1_valid = w_resp_on &  r_owner;
    assign bus.resp0_data  = bus.resp0_valid ? r_data : 32'd0;
    assign bus.resp1_data  = bus.resp1_valid ? r_data : 32'd0;
    assign bus.resp0_err   = bus.resp0_valid & r_err;
    assign bus.resp1_err   = bus.resp1_valid & r_err;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one 32-bit combinational ALU (`alu32`) between two requesters, such as the integer execute path and an address/CSR helper. Each requester uses a valid/ready request channel and a valid/ready response channel. The block arbitrates round-robin, registers the winning operands, captures the ALU result, and holds it until the owning requester accepts it. One transaction is in flight at a time.

## Interface
Parameters:
- `RR_INIT`, default 0: requester that holds priority after reset (0 or 1).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `reqN_valid` in 1 (N=0,1): request N presents an operation.
- `reqN_ready` out 1: block accepts request N this cycle.
- `reqN_op` in 6: ALU op code; bits [4:0] are decoded, bit 5 is ignored.
- `reqN_rv1`, `reqN_rv2` in 32: operands.
- `respN_valid` out 1: result for requester N is available.
- `respN_ready` in 1: requester N takes the result.
- `respN_data` out 32: result.
- `respN_err` out 1: op[4:0] was not a legal code.
- `busy` out 1: state is not IDLE.

## Operation
- Legal op[4:0] codes:
  - ADD 01000, SUB 11000
  - SLL 01001, SLT 01010, SLTU 01011
  - XOR 01100, SRL 01101, SRA 11101
  - OR 01110, AND 01111
- Any other code produces data 0 with err=1. The op is still executed.
- FSM states: IDLE, EXEC, RESP.
  - IDLE → EXEC on grant: latch op, rv1, rv2, and the 1-bit owner id.
  - EXEC → RESP unconditionally: register the ALU output into `respN_data` and the legality check into `respN_err`.
  - RESP → IDLE when `resp<owner>_valid & resp<owner>_ready`.
- Arbitration happens only in IDLE:
  - `reqN_ready` = IDLE & `reqN_valid` & (N is the winner). It is combinational.
  - If only one requester is valid, it wins regardless of the priority pointer.
  - If both are valid, the requester named by the pointer wins.
  - After every grant, the pointer is set to the non-granted requester.
- Only the owner's `respN_valid` is ever high. The other response channel stays 0 with data 0.
- Response data and err hold stable while valid is high and ready is low.
- Requests that arrive outside IDLE are not accepted. The requester keeps them asserted (standard valid/ready: valid must not drop before the handshake).
- No pipelining. A new request is never accepted in the same cycle as a response handshake.

## Timing
- Accept handshake at cycle T.
- EXEC at T+1.
- `resp_valid` high from T+2.
- With ready already high at T+2, state is IDLE at T+3, and the next grant can happen at T+3. Peak throughput is one op per 3 cycles.
- Reset values:
  - State IDLE, pointer = `RR_INIT`.
  - `resp0/1_valid` 0, `resp0/1_data` 0, `resp0/1_err` 0.
  - `busy` 0.
  - `req0/1_ready` 0 (IDLE with no valid input).
- Reset asserted mid-operation (EXEC or RESP):
  - The transaction is dropped with no response.
  - All outputs go to reset values immediately (asynchronous).
- Deassertion of `rst_n` is synchronised externally. The first grant can occur on the first edge after release.
- A `respN_ready` held high permanently is legal. A `respN_ready` toggling while `respN_valid` is low has no effect.

## Structure
- Shared package `alu_pkg`:
  - op-code localparams (ALU_ADD … ALU_AND, 5-bit)
  - function `alu_op_legal(op[4:0])`
  - FSM state typedef `arb_state_t` {IDLE, EXEC, RESP}
- Sub-module: one instance of `alu32`, fed from the latched operand registers.
- Everything else is local RTL: the arbiter, pointer, FSM, and response registers.

## Test plan
- Basic latency: req0 ADD rv1=5, rv2=7, accepted at T → resp0_valid at T+2 with data 0x0000000C, err 0; resp1_valid stays 0.
- Round-robin: after reset with RR_INIT=0, both valid (req0 SUB 10,3; req1 XOR 0xF0F0F0F0, 0xFFFF0000):
  - req0 is granted first → 7.
  - req1 is granted at the first IDLE after that → 0x0F0FF0F0.
  - With both still valid, req0 wins next.
- Signed compares: SLT rv1=0xFFFFFFFF, rv2=1 → 1; SLTU with the same operands → 0.
- Backpressure: resp1_ready held low for 5 cycles after resp1_valid (req1 SRL 0x80000000 by 4):
  - data is stable at 0x08000000;
  - busy stays 1;
  - req0_ready stays 0 throughout;
  - req0 is granted on the first cycle after the handshake.
- Illegal op: req0 op=6'b100000 → data 0, err 1; then op=6'b101000 (bit 5 set, ADD 1+1) → data 2, err 0.
- Reset mid-op: assert rst_n low during EXEC → outputs reset asynchronously and no response follows; after release, a new req0 ADD 1,2 → 3 with normal T+2 latency.
